// File: rtl/pwm_pkg.sv
// Shared constants, FSM encoding and duty clamp for the PWM generator.
package pwm_pkg;

   localparam int         PWM_STEPS = 100;
   localparam logic [7:0] DUTY_MAX  = 8'd100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pwm_state_e;

   function automatic logic [7:0] clamp_duty(input logic [7:0] duty);
      return (duty > DUTY_MAX) ? DUTY_MAX : duty;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Step-rate prescaler: oTick pulses once every PRESCALE clocks; iClr holds the count at zero.
module pwm_prescaler #(
   parameter int PRESCALE = 500
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iClr,
   output logic oTick
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic [15:0] rPre;

   assign oTick = (rPre == PRE_LAST);

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)
         rPre <= '0;
      else if (iClr || oTick)
         rPre <= '0;
      else
         rPre <= rPre + 16'd1;
   end

endmodule

// File: rtl/pwm_generator.sv
// 100-step PWM with period-boundary duty shadowing, optional soft-start ramp
// and clean start/stop on iEnable.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int PRESCALE  = 500,
   parameter int RAMP_STEP = 0
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iEnable,
   input  logic [7:0] iDuty,
   output logic       oPwm,
   output logic       oPeriodStart,
   output logic [7:0] oDuty
);

   localparam logic [6:0] CNT_LAST = 7'(PWM_STEPS - 1);
   localparam logic [8:0] RAMP_INC = 9'(RAMP_STEP);

   pwm_state_e state, state_nxt;
   logic       tick, wrap, boundary_p0, pwm_p0;
   logic [6:0] rCnt, cnt_nxt;
   logic [7:0] rActive, active_nxt;

   // Increases are limited per period; the 9-bit sum cannot overflow.
   function automatic logic [7:0] ramp_duty(input logic [7:0] target,
                                            input logic [7:0] active);
      logic [8:0] sum;
      sum = {1'b0, active} + RAMP_INC;
      if (RAMP_STEP == 0 || target <= active)
         return target;
      else if (sum > {1'b0, target})
         return target;
      else
         return sum[7:0];
   endfunction

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .iClk  (iClk),
      .iRst  (iRst),
      .iClr  (state == IDLE),
      .oTick (tick)
   );

   assign wrap = tick && (rCnt == CNT_LAST);

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (iEnable) state_nxt = RUN;
         RUN:     if (!iEnable) state_nxt = DRAIN;
         DRAIN:   if (iEnable) state_nxt = RUN;
                  else if (wrap) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next counter/duty values; the PWM compare uses them so oPwm lines up with oPeriodStart.
   always_comb begin
      unique case (state)
         IDLE:    boundary_p0 = iEnable;
         RUN:     boundary_p0 = wrap;
         DRAIN:   boundary_p0 = wrap && iEnable;
         default: boundary_p0 = 1'b0;
      endcase

      cnt_nxt = rCnt;
      if (state == IDLE || state_nxt == IDLE)
         cnt_nxt = '0;
      else if (tick)
         cnt_nxt = wrap ? 7'd0 : rCnt + 7'd1;

      active_nxt = rActive;
      if (state_nxt == IDLE)
         active_nxt = '0;
      else if (boundary_p0)
         active_nxt = ramp_duty(clamp_duty(iDuty), rActive);

      pwm_p0 = (state_nxt != IDLE) && ({1'b0, cnt_nxt} < active_nxt);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         rCnt         <= '0;
         rActive      <= '0;
         oPwm         <= 1'b0;
         oPeriodStart <= 1'b0;
      end else begin
         rCnt         <= cnt_nxt;
         rActive      <= active_nxt;
         oPwm         <= pwm_p0;
         oPeriodStart <= boundary_p0;
      end
   end

   assign oDuty = rActive;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: table vectors, directed corner sequences and random
// stimulus on three instances, all checked against a period-position model.
module tb_pwm_generator;

   typedef struct {
      bit run;
      bit stop;
      int pos;
      int duty;
      bit pwm;
      bit ps;
   } mdl_t;

   typedef struct {
      int din;
      int exp_duty;
      int exp_high;
   } vec_t;

   logic       iClk;
   logic       rst [3];
   logic       en  [3];
   logic [7:0] duty[3];
   logic       pwm [3];
   logic       ps  [3];
   logic [7:0] dty [3];

   int   vectors;
   int   miscompares;
   mdl_t mdl[3];
   int   p_of[3];
   int   r_of[3];

   pwm_generator #(.PRESCALE(1), .RAMP_STEP(0)) dut0 (
      .iClk(iClk), .iRst(rst[0]), .iEnable(en[0]), .iDuty(duty[0]),
      .oPwm(pwm[0]), .oPeriodStart(ps[0]), .oDuty(dty[0]));

   pwm_generator #(.PRESCALE(1), .RAMP_STEP(25)) dut1 (
      .iClk(iClk), .iRst(rst[1]), .iEnable(en[1]), .iDuty(duty[1]),
      .oPwm(pwm[1]), .oPeriodStart(ps[1]), .oDuty(dty[1]));

   pwm_generator #(.PRESCALE(3), .RAMP_STEP(7)) dut2 (
      .iClk(iClk), .iRst(rst[2]), .iEnable(en[2]), .iDuty(duty[2]),
      .oPwm(pwm[2]), .oPeriodStart(ps[2]), .oDuty(dty[2]));

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   function automatic int ramp_ref(int tgt, int act, int r);
      if (r == 0 || tgt <= act) return tgt;
      return (act + r < tgt) ? act + r : tgt;
   endfunction

   // pos is the clock index within the current period; step = pos / prescale.
   function automatic mdl_t mstep(mdl_t m, bit r_in, bit e, int d, int p, int r);
      mdl_t n;
      int   tgt;
      n    = m;
      n.ps = 1'b0;
      tgt  = (d > 100) ? 100 : d;
      if (r_in) begin
         n = '{default: 0};
         return n;
      end
      if (!m.run) begin
         if (e) begin
            n.run = 1'b1; n.stop = 1'b0; n.pos = 0;
            n.duty = ramp_ref(tgt, 0, r); n.ps = 1'b1;
         end
      end else if (m.pos == 100 * p - 1) begin
         if (m.stop && !e) begin
            n.run = 1'b0; n.stop = 1'b0; n.pos = 0; n.duty = 0;
         end else begin
            n.pos = 0; n.duty = ramp_ref(tgt, m.duty, r); n.ps = 1'b1; n.stop = !e;
         end
      end else begin
         n.pos = m.pos + 1; n.stop = !e;
      end
      n.pwm = n.run && ((n.pos / p) < n.duty);
      return n;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      for (int k = 0; k < 3; k++)
         mdl[k] = mstep(mdl[k], rst[k], en[k], int'(duty[k]), p_of[k], r_of[k]);
      @(posedge iClk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("d%0d_pwm", k),  int'(pwm[k]), int'(mdl[k].pwm));
         check($sformatf("d%0d_ps", k),   int'(ps[k]),  int'(mdl[k].ps));
         check($sformatf("d%0d_duty", k), int'(dty[k]), mdl[k].duty);
      end
   endtask

   // Leaves instance k in the first cycle of a freshly enabled period.
   task automatic restart(input int k, input int d);
      rst[k] = 1'b1;
      en[k]  = 1'b0;
      cyc();
      rst[k]  = 1'b0;
      duty[k] = 8'(d);
      cyc();
      en[k] = 1'b1;
      cyc();
   endtask

   initial begin
      vec_t tbl[7];
      int   seq[4];
      int   highs, first_low, psc;

      tbl[0] = '{50, 50, 50};
      tbl[1] = '{0, 0, 0};
      tbl[2] = '{100, 100, 100};
      tbl[3] = '{200, 100, 100};
      tbl[4] = '{1, 1, 1};
      tbl[5] = '{99, 99, 99};
      tbl[6] = '{255, 100, 100};
      seq    = '{25, 50, 75, 100};

      vectors = 0;
      miscompares = 0;
      p_of = '{1, 1, 3};
      r_of = '{0, 25, 7};
      for (int k = 0; k < 3; k++) begin
         mdl[k]  = '{default: 0};
         rst[k]  = 1'b1;
         en[k]   = 1'b0;
         duty[k] = 8'd0;
      end

      // Reset state
      cyc();
      cyc();
      for (int k = 0; k < 3; k++) begin
         check("reset_pwm",  int'(pwm[k]), 0);
         check("reset_ps",   int'(ps[k]),  0);
         check("reset_duty", int'(dty[k]), 0);
         rst[k] = 1'b0;
      end
      cyc();

      // Table: duty in, duty applied, high clocks per period (two periods observed)
      for (int v = 0; v < 7; v++) begin
         restart(0, tbl[v].din);
         check("tbl_first_ps", int'(ps[0]), 1);
         check("tbl_duty", int'(dty[0]), tbl[v].exp_duty);
         highs = 0; first_low = 200; psc = 0;
         for (int i = 0; i < 200; i++) begin
            if (pwm[0]) highs++;
            else if (first_low == 200) first_low = i;
            if (ps[0]) psc++;
            cyc();
         end
         check("tbl_highs", highs, 2 * tbl[v].exp_high);
         check("tbl_first_low", first_low, (tbl[v].exp_high == 100) ? 200 : tbl[v].exp_high);
         check("tbl_ps_count", psc, 2);
      end

      // Mid-period duty change takes effect only at the next boundary
      restart(0, 25);
      highs = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 10) duty[0] = 8'd75;
         if (pwm[0]) highs++;
         cyc();
      end
      check("mid_old_highs", highs, 25);
      check("mid_new_ps", int'(ps[0]), 1);
      check("mid_new_duty", int'(dty[0]), 75);
      highs = 0;
      for (int i = 0; i < 100; i++) begin
         if (pwm[0]) highs++;
         cyc();
      end
      check("mid_new_highs", highs, 75);

      // Soft-start ramp, then an immediate decrease
      restart(1, 100);
      for (int p = 0; p < 4; p++) begin
         check("ramp_ps", int'(ps[1]), 1);
         check("ramp_duty", int'(dty[1]), seq[p]);
         repeat (100) cyc();
      end
      check("ramp_hold_duty", int'(dty[1]), 100);
      duty[1] = 8'd25;
      repeat (100) cyc();
      check("ramp_drop_duty", int'(dty[1]), 25);
      check("ramp_drop_ps", int'(ps[1]), 1);

      // Stop at rCnt=30: period completes, then output stays idle
      restart(0, 60);
      repeat (30) cyc();
      en[0] = 1'b0;
      repeat (70) cyc();
      for (int i = 0; i < 5; i++) begin
         check("stop_pwm", int'(pwm[0]), 0);
         check("stop_duty", int'(dty[0]), 0);
         cyc();
      end

      // Resume, then a short drop of enable inside a period causes no gap
      en[0] = 1'b1;
      cyc();
      check("resume_ps", int'(ps[0]), 1);
      psc = 0;
      for (int i = 0; i < 250; i++) begin
         if (i == 20) en[0] = 1'b0;
         if (i == 30) en[0] = 1'b1;
         if (ps[0]) begin
            psc++;
            check("resume_ps_pos", i % 100, 0);
         end
         cyc();
      end
      check("resume_ps_count", psc, 3);

      // Asynchronous reset while oPwm is high
      restart(0, 60);
      repeat (40) cyc();
      check("arst_pre_pwm", int'(pwm[0]), 1);
      rst[0] = 1'b1;
      #1;
      check("arst_pwm", int'(pwm[0]), 0);
      check("arst_ps", int'(ps[0]), 0);
      check("arst_duty", int'(dty[0]), 0);
      cyc();
      rst[0] = 1'b0;
      cyc();
      check("arst_restart_ps", int'(ps[0]), 1);
      check("arst_restart_duty", int'(dty[0]), 60);
      highs = 0;
      for (int i = 0; i < 100; i++) begin
         if (pwm[0]) highs++;
         cyc();
      end
      check("arst_restart_highs", highs, 60);

      // Random stimulus on all three instances
      for (int k = 0; k < 3; k++) begin
         en[k] = 1'b1;
         duty[k] = 8'($urandom_range(0, 255));
      end
      for (int n = 0; n < 6000; n++) begin
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 149) == 0) en[k] = ~en[k];
            if ($urandom_range(0, 39) == 0) duty[k] = 8'($urandom_range(0, 255));
            if (rst[k]) begin
               if ($urandom_range(0, 3) == 0) rst[k] = 1'b0;
            end else if ($urandom_range(0, 699) == 0) begin
               rst[k] = 1'b1;
            end
         end
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
